// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side signal bundle for pipe_hazard_ctrl: D/E/M hazard inputs,
// MDU start request, and the PC / F-D / D-E register controls it returns.
interface pipe_hazard_ctrl_if;
  logic [4:0] d_rs;
  logic [4:0] d_rt;
  logic [1:0] d_rs_tuse;
  logic [1:0] d_rt_tuse;
  logic       d_md;
  logic [4:0] e_wa;
  logic [4:0] m_wa;
  logic [1:0] e_tnew;
  logic [1:0] m_tnew;
  logic       e_md_start;
  logic       e_md_div;
  logic       pc_en;
  logic       fd_en;
  logic       de_flush;
  logic       md_busy;
  logic       md_done;

  // Pipeline datapath side.
  modport master (
    output d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_md,
    output e_wa, m_wa, e_tnew, m_tnew, e_md_start, e_md_div,
    input  pc_en, fd_en, de_flush, md_busy, md_done
  );

  // Hazard controller side.
  modport slave (
    input  d_rs, d_rt, d_rs_tuse, d_rt_tuse, d_md,
    input  e_wa, m_wa, e_tnew, m_tnew, e_md_start, e_md_div,
    output pc_en, fd_en, de_flush, md_busy, md_done
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush controller for the five-stage pipeline: Tuse/Tnew operand hazards
// plus multiply/divide busy sequencing. Define PIPE_HAZARD_CTRL_PERF_EN for stall_cycles.
module pipe_hazard_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_hazard_ctrl_if.slave    bus
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]          stall_cycles
`endif
);

  localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
  localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

  // A source stalls when an in-flight producer's result arrives later than
  // the consumer needs it. Tuse = 3 and Tnew = 0 fall out of the compare.
  function automatic logic operand_hazard(
    input logic [4:0] src,
    input logic [1:0] tuse,
    input logic [4:0] e_wa,
    input logic [1:0] e_tnew,
    input logic [4:0] m_wa,
    input logic [1:0] m_tnew
  );
    logic e_hit;
    logic m_hit;
    e_hit = (src == e_wa) && (e_tnew > tuse);
    m_hit = (src == m_wa) && (m_tnew > tuse);
    return (src != 5'd0) && (e_hit || m_hit);
  endfunction

  logic [3:0] cnt;
  logic [3:0] cnt_next;
  logic       md_done_q;
  logic       md_done_next;
  logic       md_busy;
  logic       rs_hazard;
  logic       rt_hazard;
  logic       md_hazard;
  logic       stall;

  // NOTE: every variable written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    cnt_next     = cnt;
    md_done_next = 1'b0;
    if (bus.e_md_start && (cnt == 4'd0)) begin
      cnt_next     = bus.e_md_div ? DIV_LOAD : MULT_LOAD;
      md_done_next = (cnt_next == 4'd0);
    end else if (cnt != 4'd0) begin
      cnt_next     = cnt - 4'd1;
      md_done_next = (cnt == 4'd1);
    end
  end

  // NOTE: sequential state uses non-blocking assignment so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= 4'd0;
      md_done_q <= 1'b0;
    end else begin
      cnt       <= cnt_next;
      md_done_q <= md_done_next;
    end
  end

  assign md_busy   = bus.e_md_start | (cnt != 4'd0);
  assign rs_hazard = operand_hazard(bus.d_rs, bus.d_rs_tuse, bus.e_wa, bus.e_tnew,
                                    bus.m_wa, bus.m_tnew);
  assign rt_hazard = operand_hazard(bus.d_rt, bus.d_rt_tuse, bus.e_wa, bus.e_tnew,
                                    bus.m_wa, bus.m_tnew);
  assign md_hazard = bus.d_md & md_busy;
  assign stall     = rs_hazard | rt_hazard | md_hazard;

  assign bus.pc_en    = ~stall;
  assign bus.fd_en    = ~stall;
  assign bus.de_flush = stall;
  assign bus.md_busy  = md_busy;
  assign bus.md_done  = md_done_q;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= 32'd0;
    end else if (stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

- Stall/flush controller for the five-stage pipeline.
- Detects decode-stage operand hazards against in-flight producers in E and M using Tuse/Tnew.
- Sequences the multi-cycle multiply/divide unit with a busy counter.
- Drives the enable and flush controls of the PC, F/D and D/E pipeline registers. E/M and M/W always advance.

## Interface
- MULT_CYCLES, 5, busy cycles for mult/multu; legal range 1..15
- DIV_CYCLES, 10, busy cycles for div/divu; legal range 1..15
- clk  in  1  pipeline clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- d_rs, d_rt  in  5 each  source register numbers of the instruction in D
- d_rs_tuse, d_rt_tuse  in  2 each  cycles until operand needed (0..2); 3 = operand unused
- d_md  in  1  D instruction uses HI/LO/MDU (mult, div, mfhi, mflo, mthi, mtlo)
- e_wa, m_wa  in  5 each  destination register of the instruction in E / M; 0 = no write
- e_tnew, m_tnew  in  2 each  cycles until that result is forwardable (0..2)
- e_md_start  in  1  instruction in E starts the MDU this cycle
- e_md_div  in  1  qualifies e_md_start: 1 = divide, 0 = multiply
- pc_en  out  1  PC write enable
- fd_en  out  1  F/D register enable
- de_flush  out  1  D/E register synchronous clear (bubble insert)
- md_busy  out  1  MDU occupied
- md_done  out  1  one-cycle pulse, first cycle after MDU finishes

## Operation
- Operand hazard on rs is asserted when:
  - d_rs != 0, and
  - either (d_rs == e_wa and e_tnew > d_rs_tuse) or (d_rs == m_wa and m_tnew > d_rs_tuse).
- Operand hazard on rt is the same test using d_rt and d_rt_tuse.
- Tuse = 3 never stalls. Tnew = 0 never stalls. Comparisons are unsigned 2-bit.
- Register number 0 never hazards, even when e_wa/m_wa = 0.
- MDU counter cnt is 4 bits.
  - When e_md_start = 1 and cnt = 0, cnt loads (e_md_div ? DIV_CYCLES : MULT_CYCLES) − 1.
  - Otherwise cnt decrements while nonzero.
- md_busy = e_md_start | (cnt != 0). This output is combinational.
- e_md_start arriving while cnt != 0 is ignored: the counter is not reloaded. Correct stall behaviour prevents this case.
- MDU hazard is asserted when d_md & md_busy.
- stall = rs hazard | rt hazard | MDU hazard.
  - pc_en = ~stall.
  - fd_en = ~stall.
  - de_flush = stall.
- md_done is a register. It is set on the edge where cnt transitions 1→0, or where a start with a 1-cycle latency is accepted. It clears on the next edge.

## Timing
- Values while reset is low (reset clears cnt and md_done):
  - cnt = 0 and md_done = 0.
  - md_busy = e_md_start.
  - Remaining outputs follow the combinational equations.
- With all inputs at 0 during reset: pc_en = 1, fd_en = 1, de_flush = 0.
- Hazard outputs are combinational, with zero latency from the D/E/M inputs within the same cycle.
- MDU start accepted in cycle t with latency N:
  - md_busy is high in cycles t .. t+N−1 (exactly N cycles).
  - md_done is high in cycle t+N only.
- Back-to-back MDU ops: a new start in cycle t+N is accepted, so md_busy stays continuously high. md_done still pulses in t+N.
- Reset asserted mid-operation aborts the count: md_busy drops (unless e_md_start is high) and no md_done pulse is produced.
- Parameter values outside 1..15 are illegal and unchecked.

## Configuration
- PIPE_HAZARD_CTRL_PERF_EN defined:
  - Adds output stall_cycles (out, 32 bits).
  - The counter increments on every rising edge where stall = 1 and saturates at 0xFFFFFFFF.
  - Reset value 0.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Load-use:
  - Stimulus: e_wa=8, e_tnew=2, d_rs=8, d_rs_tuse=1.
  - Required: stall (pc_en=0, fd_en=0, de_flush=1).
  - Next cycle, with m_wa=8, m_tnew=1: stall=0.
- Zero register and unused operands:
  - Stimulus: d_rs=0 matched against e_wa=0 with e_tnew=2 → no stall.
  - Stimulus: d_rt=5, e_wa=5, e_tnew=2, d_rt_tuse=3 → no stall.
- Divide busy:
  - Stimulus: e_md_start=1, e_md_div=1 at cycle 0, d_md=1 held.
  - Required: md_busy and stall high in cycles 0..9; md_done high in cycle 10 only; stall=0 in cycle 10.
- Multiply, then start while busy:
  - Stimulus: mult starts at cycle 0; e_md_start pulses again at cycle 2.
  - Required: md_busy falls after cycle 4; md_done pulses in cycle 5; no reload.
- Reset mid-divide:
  - Stimulus: reset low at cycle 3 of a divide.
  - Required: md_busy=0 immediately; md_done stays 0; cnt=0 after release.
- PERF_EN build:
  - Stimulus: a 10-cycle divide stall followed by 3 idle cycles.
  - Required: stall_cycles = 10. Reset clears it to 0.
